sram_init_ctrl: RTL and testbench

Parametrised SRAM initialisation controller and port arbiter between the microcontroller and the init path. On a start pulse it writes a programmable range of SRAM words, either drained from the init FIFO (load mode) or set to a constant pattern (fill mode). It owns the SRAM port only while a transfer runs. Its write strobe length is configurable, and it reports progress, completion and errors.

---
 rtl/sram_init_ctrl.sv | 167 ++++++++++++++++
 tb/tb_sram_init_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_init_ctrl.sv
// SRAM initialisation controller: fills a programmable address range from the init FIFO
// or with a constant pattern, and arbitrates the SRAM port against the microcontroller.
module sram_init_ctrl #(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 32,
    parameter int WRITE_CYCLES  = 1
) (
    input  logic                     sram_init_ctrl_clk_i,
    input  logic                     sram_init_ctrl_rst_i,
    input  logic [ADDRESS_WIDTH-1:0] micro_sram_address_i,
    input  logic [DATA_WIDTH-1:0]    micro_sram_datain_i,
    input  logic                     micro_sram_cs_i,
    input  logic                     micro_sram_we_i,
    input  logic                     init_start_i,
    input  logic                     init_abort_i,
    input  logic                     init_mode_i,
    input  logic [ADDRESS_WIDTH-1:0] init_base_addr_i,
    input  logic [ADDRESS_WIDTH:0]   init_length_i,
    input  logic [DATA_WIDTH-1:0]    init_fill_data_i,
    input  logic [DATA_WIDTH-1:0]    fifo_datain_i,
    input  logic                     fifo_empty_i,
    output logic                     read_fifo_o,
    output logic [ADDRESS_WIDTH-1:0] sram_address_o,
    output logic [DATA_WIDTH-1:0]    sram_datain_o,
    output logic                     sram_cs_o,
    output logic                     sram_we_o,
    output logic                     init_busy_o,
    output logic                     init_done_o,
    output logic                     init_error_o,
    output logic [ADDRESS_WIDTH:0]   init_count_o,
    output logic                     micro_blocked_o
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_LATCH   = 3'd2,
        ST_WRITE   = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

    localparam logic [ADDRESS_WIDTH:0]   MAX_LEN  = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0]   LEN_ZERO = {(ADDRESS_WIDTH+1){1'b0}};
    localparam logic [ADDRESS_WIDTH:0]   LEN_ONE  = (ADDRESS_WIDTH+1)'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = ADDRESS_WIDTH'(1);
    localparam logic [3:0]               WC_LAST  = 4'(WRITE_CYCLES - 1);

    state_t                   state_q;
    logic                     mode_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic [ADDRESS_WIDTH:0]   remaining_q;
    logic [ADDRESS_WIDTH:0]   count_q;
    logic [3:0]               wcnt_q;
    logic                     done_q;
    logic                     error_q;

    logic                     len_ok_s;
    logic                     strobe_s;
    logic [ADDRESS_WIDTH:0]   count_d;
    logic [ADDRESS_WIDTH:0]   remaining_d;
    logic [ADDRESS_WIDTH-1:0] addr_d;

    // Next values applied at the end of each RELEASE; address wraps naturally.
    always_comb begin
        count_d     = count_q + LEN_ONE;
        remaining_d = remaining_q - LEN_ONE;
        addr_d      = addr_q + ADDR_ONE;
        len_ok_s    = (init_length_i != LEN_ZERO) && (init_length_i <= MAX_LEN);
    end

    // Transfer FSM with its datapath registers.
    always_ff @(posedge sram_init_ctrl_clk_i) begin
        if (sram_init_ctrl_rst_i) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            addr_q      <= {ADDRESS_WIDTH{1'b0}};
            data_q      <= {DATA_WIDTH{1'b0}};
            remaining_q <= LEN_ZERO;
            count_q     <= LEN_ZERO;
            wcnt_q      <= 4'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (init_start_i) begin
                        if (len_ok_s) begin
                            mode_q      <= init_mode_i;
                            addr_q      <= init_base_addr_i;
                            remaining_q <= init_length_i;
                            count_q     <= LEN_ZERO;
                            done_q      <= 1'b0;
                            wcnt_q      <= 4'd0;
                            if (init_mode_i) begin
                                data_q  <= init_fill_data_i;
                                state_q <= ST_WRITE;
                            end else begin
                                state_q <= ST_FETCH;
                            end
                        end else begin
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_FETCH: begin
                    // Abort has priority over a pop so no word is lost mid-flight.
                    if (init_abort_i) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (!fifo_empty_i) begin
                        state_q <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    data_q  <= fifo_datain_i;
                    wcnt_q  <= 4'd0;
                    state_q <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (wcnt_q == WC_LAST) begin
                        wcnt_q  <= 4'd0;
                        state_q <= ST_RELEASE;
                    end else begin
                        wcnt_q  <= wcnt_q + 4'd1;
                    end
                end
                ST_RELEASE: begin
                    count_q     <= count_d;
                    remaining_q <= remaining_d;
                    addr_q      <= addr_d;
                    // Completion of the final word takes precedence over a late abort.
                    if (remaining_q == LEN_ONE) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (init_abort_i) begin
                        error_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end else if (mode_q) begin
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign strobe_s        = (state_q != ST_WRITE);
    assign init_busy_o     = (state_q != ST_IDLE);
    assign read_fifo_o     = (state_q == ST_FETCH) && !fifo_empty_i && !init_abort_i;
    assign micro_blocked_o = init_busy_o && !micro_sram_cs_i;

    assign sram_address_o  = init_busy_o ? addr_q   : micro_sram_address_i;
    assign sram_datain_o   = init_busy_o ? data_q   : micro_sram_datain_i;
    assign sram_cs_o       = init_busy_o ? strobe_s : micro_sram_cs_i;
    assign sram_we_o       = init_busy_o ? strobe_s : micro_sram_we_i;

    assign init_done_o     = done_q;
    assign init_error_o    = error_q;
    assign init_count_o    = count_q;

endmodule

// File: tb/tb_sram_init_ctrl.sv
// Directed bench for sram_init_ctrl: FIFO model, SRAM write log and hand-computed expectations.
module tb_sram_init_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] micro_addr = 13'h0000;
    logic [31:0] micro_data = 32'h0;
    logic        micro_cs = 1'b1;
    logic        micro_we = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        mode = 1'b0;
    logic [12:0] base = 13'h0000;
    logic [13:0] length = 14'h0000;
    logic [31:0] fill = 32'h0;
    logic [31:0] fifo_data = 32'h0;
    logic        fifo_empty;
    logic        gap = 1'b0;

    logic        read_fifo_o;
    logic [12:0] sram_address_o;
    logic [31:0] sram_datain_o;
    logic        sram_cs_o, sram_we_o;
    logic        init_busy_o, init_done_o, init_error_o, micro_blocked_o;
    logic [13:0] init_count_o;

    logic [31:0] fifo_mem [0:31];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [12:0] log_addr [0:63];
    logic [31:0] log_data [0:63];
    int          wr_n = 0, pop_n = 0, busy_cyc = 0, err_n = 0;
    int          total = 0, bad = 0;

    assign fifo_empty = (rd_ptr == wr_ptr) || gap;

    sram_init_ctrl #(.ADDRESS_WIDTH(13), .DATA_WIDTH(32), .WRITE_CYCLES(1)) dut (
        .sram_init_ctrl_clk_i (clk),
        .sram_init_ctrl_rst_i (rst),
        .micro_sram_address_i (micro_addr),
        .micro_sram_datain_i  (micro_data),
        .micro_sram_cs_i      (micro_cs),
        .micro_sram_we_i      (micro_we),
        .init_start_i         (start),
        .init_abort_i         (abort),
        .init_mode_i          (mode),
        .init_base_addr_i     (base),
        .init_length_i        (length),
        .init_fill_data_i     (fill),
        .fifo_datain_i        (fifo_data),
        .fifo_empty_i         (fifo_empty),
        .read_fifo_o          (read_fifo_o),
        .sram_address_o       (sram_address_o),
        .sram_datain_o        (sram_datain_o),
        .sram_cs_o            (sram_cs_o),
        .sram_we_o            (sram_we_o),
        .init_busy_o          (init_busy_o),
        .init_done_o          (init_done_o),
        .init_error_o         (init_error_o),
        .init_count_o         (init_count_o),
        .micro_blocked_o      (micro_blocked_o)
    );

    always #5 clk = ~clk;

    // FIFO read port, SRAM write log and event counters.
    always @(posedge clk) begin
        if (read_fifo_o) begin
            fifo_data <= fifo_mem[rd_ptr[4:0]];
            rd_ptr    <= rd_ptr + 1;
            pop_n     <= pop_n + 1;
        end
        if (init_busy_o && !sram_cs_o && !sram_we_o) begin
            if (wr_n < 64) begin
                log_addr[wr_n[5:0]] <= sram_address_o;
                log_data[wr_n[5:0]] <= sram_datain_o;
            end
            wr_n <= wr_n + 1;
        end
        if (init_busy_o)  busy_cyc <= busy_cyc + 1;
        if (init_error_o) err_n    <= err_n + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        fifo_mem[wr_ptr[4:0]] = v;
        wr_ptr++;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (init_busy_o === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check(tag, 64'(init_busy_o), 64'd0);
    endtask

    task automatic do_start(input logic m, input logic [12:0] b, input logic [13:0] l,
                            input logic [31:0] f);
        mode = m; base = b; length = l; fill = f; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int w0, p0, b0, e0;
        logic [12:0] ea;

        // Reset state
        micro_addr = 13'h00AB; micro_data = 32'h1111_2222;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 64'(init_busy_o), 64'd0);
        check("rst_done", 64'(init_done_o), 64'd0);
        check("rst_err", 64'(init_error_o), 64'd0);
        check("rst_count", 64'(init_count_o), 64'd0);
        check("rst_rdfifo", 64'(read_fifo_o), 64'd0);
        check("rst_blocked", 64'(micro_blocked_o), 64'd0);
        check("rst_addr_pass", 64'(sram_address_o), 64'h00AB);
        check("rst_data_pass", 64'(sram_datain_o), 64'h1111_2222);
        check("rst_cs_pass", 64'(sram_cs_o), 64'd1);

        // Load mode: 4 words, 16 busy cycles
        for (int i = 0; i < 4; i++) push(32'hA0 + 32'(i));
        w0 = wr_n; p0 = pop_n; b0 = busy_cyc;
        do_start(1'b0, 13'h0010, 14'd4, 32'h0);
        check("t1_busy_rise", 64'(init_busy_o), 64'd1);
        check("t1_first_pop", 64'(read_fifo_o), 64'd1);
        wait_idle(100, "t1_timeout");
        check("t1_done", 64'(init_done_o), 64'd1);
        check("t1_count", 64'(init_count_o), 64'd4);
        check("t1_pops", 64'(pop_n - p0), 64'd4);
        check("t1_writes", 64'(wr_n - w0), 64'd4);
        check("t1_busy_cyc", 64'(busy_cyc - b0), 64'd16);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", 64'(log_addr[w0 + i]), 64'h0010 + 64'(i));
            check("t1_data", 64'(log_data[w0 + i]), 64'hA0 + 64'(i));
        end

        // Fill mode with address wrap
        w0 = wr_n; p0 = pop_n; b0 = busy_cyc;
        do_start(1'b1, 13'h1FFE, 14'd4, 32'hDEAD_BEEF);
        check("t2_done_clr", 64'(init_done_o), 64'd0);
        wait_idle(100, "t2_timeout");
        check("t2_done", 64'(init_done_o), 64'd1);
        check("t2_count", 64'(init_count_o), 64'd4);
        check("t2_busy_cyc", 64'(busy_cyc - b0), 64'd8);
        check("t2_no_pops", 64'(pop_n - p0), 64'd0);
        check("t2_writes", 64'(wr_n - w0), 64'd4);
        for (int i = 0; i < 4; i++) begin
            ea = 13'h1FFE + 13'(i);
            check("t2_addr", 64'(log_addr[w0 + i]), 64'(ea));
            check("t2_data", 64'(log_data[w0 + i]), 64'hDEAD_BEEF);
        end

        // Load mode with a 5-cycle FIFO gap between words 1 and 2
        for (int i = 0; i < 4; i++) push(32'hB0 + 32'(i));
        w0 = wr_n; p0 = pop_n; b0 = busy_cyc;
        do_start(1'b0, 13'h0100, 14'd4, 32'h0);
        tick();
        gap = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t3_gap_rdfifo", 64'(read_fifo_o), 64'd0);
        check("t3_gap_cs", 64'(sram_cs_o), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        gap = 1'b0;
        wait_idle(100, "t3_timeout");
        check("t3_busy_cyc", 64'(busy_cyc - b0), 64'd21);
        check("t3_pops", 64'(pop_n - p0), 64'd4);
        check("t3_count", 64'(init_count_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("t3_addr", 64'(log_addr[w0 + i]), 64'h0100 + 64'(i));
            check("t3_data", 64'(log_data[w0 + i]), 64'hB0 + 64'(i));
        end

        // Abort during the WRITE of word 2 of 8
        for (int i = 0; i < 8; i++) push(32'hC0 + 32'(i));
        w0 = wr_n; p0 = pop_n; e0 = err_n;
        do_start(1'b0, 13'h0200, 14'd8, 32'h0);
        for (int i = 0; i < 6; i++) tick();
        abort = 1'b1;
        #1;
        check("t4_in_write", 64'(sram_cs_o), 64'd0);
        tick();
        check("t4_release_busy", 64'(init_busy_o), 64'd1);
        tick();
        abort = 1'b0;
        check("t4_idle", 64'(init_busy_o), 64'd0);
        check("t4_err_pulse", 64'(init_error_o), 64'd1);
        check("t4_count", 64'(init_count_o), 64'd2);
        check("t4_done", 64'(init_done_o), 64'd0);
        tick();
        check("t4_err_clear", 64'(init_error_o), 64'd0);
        check("t4_pops", 64'(pop_n - p0), 64'd2);
        check("t4_writes", 64'(wr_n - w0), 64'd2);
        check("t4_err_cnt", 64'(err_n - e0), 64'd1);
        check("t4_data1", 64'(log_data[w0 + 1]), 64'hC1);

        // Rejected starts: length 0 and length 0x2001
        e0 = err_n; b0 = busy_cyc;
        do_start(1'b1, 13'h0000, 14'h0000, 32'h0);
        check("t5_len0_err", 64'(init_error_o), 64'd1);
        check("t5_len0_busy", 64'(init_busy_o), 64'd0);
        tick();
        check("t5_len0_err_clr", 64'(init_error_o), 64'd0);
        do_start(1'b1, 13'h0000, 14'h2001, 32'h0);
        check("t5_big_err", 64'(init_error_o), 64'd1);
        check("t5_big_busy", 64'(init_busy_o), 64'd0);
        tick();
        check("t5_err_cnt", 64'(err_n - e0), 64'd2);
        check("t5_no_busy", 64'(busy_cyc - b0), 64'd0);
        check("t5_count_kept", 64'(init_count_o), 64'd2);

        // Maximum length fill with a blocked micro access
        b0 = busy_cyc;
        do_start(1'b1, 13'h0000, 14'h2000, 32'hA5A5_A5A5);
        micro_cs = 1'b0; micro_we = 1'b0; micro_addr = 13'h0555; micro_data = 32'h1234_5678;
        #1;
        check("t6_blocked", 64'(micro_blocked_o), 64'd1);
        check("t6_int_addr", 64'(sram_address_o), 64'h0000);
        check("t6_int_data", 64'(sram_datain_o), 64'hA5A5_A5A5);
        tick();
        check("t6_release_cs", 64'(sram_cs_o), 64'd1);
        check("t6_release_we", 64'(sram_we_o), 64'd1);
        micro_cs = 1'b1; micro_we = 1'b1;
        #1;
        check("t6_unblocked", 64'(micro_blocked_o), 64'd0);
        wait_idle(20000, "t6_timeout");
        check("t6_count", 64'(init_count_o), 64'h2000);
        check("t6_done", 64'(init_done_o), 64'd1);
        check("t6_busy_cyc", 64'(busy_cyc - b0), 64'd16384);

        // Reset asserted mid-WRITE
        do_start(1'b1, 13'h0100, 14'd10, 32'h0000_0055);
        w0 = wr_n;
        rst = 1'b1;
        micro_addr = 13'h0777; micro_data = 32'hCAFE_F00D; micro_cs = 1'b0; micro_we = 1'b1;
        tick();
        check("t7_busy", 64'(init_busy_o), 64'd0);
        check("t7_done", 64'(init_done_o), 64'd0);
        check("t7_err", 64'(init_error_o), 64'd0);
        check("t7_count", 64'(init_count_o), 64'd0);
        check("t7_rdfifo", 64'(read_fifo_o), 64'd0);
        check("t7_blocked", 64'(micro_blocked_o), 64'd0);
        check("t7_addr_pass", 64'(sram_address_o), 64'h0777);
        check("t7_data_pass", 64'(sram_datain_o), 64'hCAFE_F00D);
        check("t7_cs_pass", 64'(sram_cs_o), 64'd0);
        check("t7_we_pass", 64'(sram_we_o), 64'd1);
        rst = 1'b0; micro_cs = 1'b1;
        tick(); tick(); tick();
        check("t7_no_more_writes", 64'(wr_n - w0), 64'd1);
        check("t7_idle_after", 64'(init_busy_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
